// File: rtl/yuv_downsample_encoder.sv
// rtl/yuv_downsample_encoder.sv - RGB to YUV (BT.601 Q16) encoder with 2:1 horizontal chroma downsampling over a shared SRAM port
// Optional feature macro: YUV_ENC_CHROMA_AVG_EN (average chroma pairs instead of even-pixel decimation)
module yuv_downsample_encoder #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter logic [17:0] Y_BASE     = 18'd0,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600,
    parameter int          NUM_GROUPS = 19200
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done
);
    typedef enum logic [4:0] {
        S_IDLE,
        S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RD6, S_RD7,
        S_C0, S_C1, S_C2, S_C3, S_C4, S_C5, S_C6, S_C7, S_C8, S_C9, S_C10, S_C11,
        S_WR0, S_WR1, S_WR2, S_WR3,
        S_DONE
    } state_e;

    localparam logic [14:0] LAST_G = 15'(NUM_GROUPS - 1);

    state_e      state_q, state_d;
    logic [14:0] g_q, g_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        done_q, done_d;
    logic [15:0] rgb_q [6];
    logic [15:0] rgb_d [6];
    logic [7:0]  y_q [4];
    logic [7:0]  y_d [4];
    logic [7:0]  u_q [4];
    logic [7:0]  u_d [4];
    logic [7:0]  v_q [4];
    logic [7:0]  v_d [4];

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Done            = done_q;

    logic [2:0]  rd_off, cap_idx;
    logic [17:0] rd_addr;
    assign rd_off  = 3'(state_q - S_RD0);
    assign cap_idx = 3'(state_q - S_RD2);
    assign rd_addr = RGB_BASE + 18'(g_q) * 18'd6 + {15'd0, rd_off};

    // Compute schedule: pixel p in states C(3p)..C(3p+2), component Y/U/V in that order
    logic [1:0] pix_sel, comp_sel;
    always_comb begin
        pix_sel  = 2'd0;
        comp_sel = 2'd0;
        case (state_q)
            S_C0:  begin pix_sel = 2'd0; comp_sel = 2'd0; end
            S_C1:  begin pix_sel = 2'd0; comp_sel = 2'd1; end
            S_C2:  begin pix_sel = 2'd0; comp_sel = 2'd2; end
            S_C3:  begin pix_sel = 2'd1; comp_sel = 2'd0; end
            S_C4:  begin pix_sel = 2'd1; comp_sel = 2'd1; end
            S_C5:  begin pix_sel = 2'd1; comp_sel = 2'd2; end
            S_C6:  begin pix_sel = 2'd2; comp_sel = 2'd0; end
            S_C7:  begin pix_sel = 2'd2; comp_sel = 2'd1; end
            S_C8:  begin pix_sel = 2'd2; comp_sel = 2'd2; end
            S_C9:  begin pix_sel = 2'd3; comp_sel = 2'd0; end
            S_C10: begin pix_sel = 2'd3; comp_sel = 2'd1; end
            S_C11: begin pix_sel = 2'd3; comp_sel = 2'd2; end
            default: ;
        endcase
    end

    // Pixel pair packing in the buffer: {R0,G0},{B0,R1},{G1,B1}
    logic [7:0] px_r, px_g, px_b;
    always_comb begin
        px_r = rgb_q[0][15:8];
        px_g = rgb_q[0][7:0];
        px_b = rgb_q[1][15:8];
        case (pix_sel)
            2'd1: begin px_r = rgb_q[1][7:0]; px_g = rgb_q[2][15:8]; px_b = rgb_q[2][7:0]; end
            2'd2: begin px_r = rgb_q[3][15:8]; px_g = rgb_q[3][7:0]; px_b = rgb_q[4][15:8]; end
            2'd3: begin px_r = rgb_q[4][7:0]; px_g = rgb_q[5][15:8]; px_b = rgb_q[5][7:0]; end
            default: ;
        endcase
    end

    logic signed [31:0] c_r, c_g, c_b, c_off, acc, shifted;
    logic [7:0]         comp_val;
    always_comb begin
        c_r   = 32'sd16843;
        c_g   = 32'sd33030;
        c_b   = 32'sd6423;
        c_off = 32'sd1048576;
        case (comp_sel)
            2'd1: begin c_r = -32'sd9699; c_g = -32'sd19071; c_b = 32'sd28770; c_off = 32'sd8388608; end
            2'd2: begin c_r = 32'sd28770; c_g = -32'sd24117; c_b = -32'sd4653; c_off = 32'sd8388608; end
            default: ;
        endcase
        acc = c_r * $signed({24'd0, px_r}) + c_g * $signed({24'd0, px_g})
            + c_b * $signed({24'd0, px_b}) + c_off + 32'sd32768;
        shifted  = acc >>> 16;
        comp_val = shifted[7:0];
        if (shifted < 32'sd0) begin
            comp_val = 8'd0;
        end else if (shifted > 32'sd255) begin
            comp_val = 8'd255;
        end
    end

    logic [7:0] ud_lo, ud_hi, vd_lo, vd_hi;
`ifdef YUV_ENC_CHROMA_AVG_EN
    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction
    assign ud_lo = avg2(u_q[0], u_q[1]);
    assign ud_hi = avg2(u_q[2], u_q[3]);
    assign vd_lo = avg2(v_q[0], v_q[1]);
    assign vd_hi = avg2(v_q[2], v_q[3]);
`else
    assign ud_lo = u_q[0];
    assign ud_hi = u_q[2];
    assign vd_lo = v_q[0];
    assign vd_hi = v_q[2];
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        done_d  = 1'b0;
        rgb_d   = rgb_q;
        y_d     = y_q;
        u_d     = u_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    state_d = S_RD0;
                    g_d     = '0;
                end
            end
            S_WR0: begin
                we_n_d  = 1'b0;
                addr_d  = Y_BASE + 18'({g_q, 1'b0});
                wdata_d = {y_q[0], y_q[1]};
                state_d = S_WR1;
            end
            S_WR1: begin
                we_n_d  = 1'b0;
                addr_d  = Y_BASE + 18'({g_q, 1'b1});
                wdata_d = {y_q[2], y_q[3]};
                state_d = S_WR2;
            end
            S_WR2: begin
                we_n_d  = 1'b0;
                addr_d  = U_BASE + 18'(g_q);
                wdata_d = {ud_lo, ud_hi};
                state_d = S_WR3;
            end
            S_WR3: begin
                we_n_d  = 1'b0;
                addr_d  = V_BASE + 18'(g_q);
                wdata_d = {vd_lo, vd_hi};
                if (g_q == LAST_G) begin
                    state_d = S_DONE;
                end else begin
                    g_d     = g_q + 15'd1;
                    state_d = S_RD0;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = (state_q < S_DONE) ? state_e'(state_q + 5'd1) : S_IDLE;
        endcase
        if (state_q >= S_RD0 && state_q <= S_RD5) begin
            addr_d = rd_addr;
        end
        // SRAM returns data two edges after the address, so RDk+2 holds word k
        if (state_q >= S_RD2 && state_q <= S_RD7) begin
            rgb_d[cap_idx] = SRAM_read_data;
        end
        if (state_q >= S_C0 && state_q <= S_C11) begin
            case (comp_sel)
                2'd0:    y_d[pix_sel] = comp_val;
                2'd1:    u_d[pix_sel] = comp_val;
                default: v_d[pix_sel] = comp_val;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            done_q  <= 1'b0;
            for (int i = 0; i < 6; i++) rgb_q[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
                u_q[i] <= '0;
                v_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            done_q  <= done_d;
            rgb_q   <= rgb_d;
            y_q     <= y_d;
            u_q     <= u_d;
            v_q     <= v_d;
        end
    end
endmodule

// File: tb/tb_yuv_downsample_encoder.sv
// tb/tb_yuv_downsample_encoder.sv - self-checking bench for yuv_downsample_encoder against a pixel-level YUV model
module tb_yuv_downsample_encoder;
    localparam int N        = 8;
    localparam int RGB_BASE = 146944;
    localparam int Y_BASE   = 0;
    localparam int U_BASE   = 38400;
    localparam int V_BASE   = 57600;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Enable = 1'b0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data = '0;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Done;

    yuv_downsample_encoder #(.NUM_GROUPS(N)) dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
        .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data),
        .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .Done(Done)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [0:262143];
    logic [15:0] wr_data [0:262143];
    int          wr_run [0:262143];
    int          run_id = 0, wr_count = 0, oor_count = 0, cyc = 0;
    int          tests = 0, fails = 0;
    int          pr [4*N];
    int          pg [4*N];
    int          pb [4*N];

    function automatic bit valid_wr(input int a);
        return (a >= Y_BASE && a < Y_BASE + 2*N) || (a >= U_BASE && a < U_BASE + N)
            || (a >= V_BASE && a < V_BASE + N);
    endfunction

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        SRAM_read_data <= mem[SRAM_address];
        if (!SRAM_we_n) begin
            wr_data[SRAM_address] <= SRAM_write_data;
            wr_run[SRAM_address]  <= run_id;
            wr_count <= wr_count + 1;
            if (!valid_wr(int'(SRAM_address))) oor_count <= oor_count + 1;
        end
    end

    function automatic int conv(input int r, input int g, input int b, input int k);
        int a;
        if (k == 0)      a = 16843*r + 33030*g + 6423*b + (16 << 16);
        else if (k == 1) a = -9699*r - 19071*g + 28770*b + (128 << 16);
        else             a = 28770*r - 24117*g - 4653*b + (128 << 16);
        a = (a + 32768) >>> 16;
        if (a < 0) return 0;
        if (a > 255) return 255;
        return a;
    endfunction

    function automatic int pix(input int p, input int k);
        return conv(pr[p], pg[p], pb[p], k);
    endfunction

    function automatic int chroma(input int p_even, input int k);
`ifdef YUV_ENC_CHROMA_AVG_EN
        return (pix(p_even, k) + pix(p_even + 1, k) + 1) >> 1;
`else
        return pix(p_even, k);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int addr, input logic [15:0] exp);
        check(tag, {15'd0, wr_run[addr] != run_id, wr_data[addr]}, {16'd0, exp});
    endtask

    task automatic check_image(input string tag);
        for (int g = 0; g < N; g++) begin
            check_word($sformatf("%s Y[%0d]", tag, 2*g), Y_BASE + 2*g,
                       {8'(pix(4*g, 0)), 8'(pix(4*g + 1, 0))});
            check_word($sformatf("%s Y[%0d]", tag, 2*g + 1), Y_BASE + 2*g + 1,
                       {8'(pix(4*g + 2, 0)), 8'(pix(4*g + 3, 0))});
            check_word($sformatf("%s U[%0d]", tag, g), U_BASE + g,
                       {8'(chroma(4*g, 1)), 8'(chroma(4*g + 2, 1))});
            check_word($sformatf("%s V[%0d]", tag, g), V_BASE + g,
                       {8'(chroma(4*g, 2)), 8'(chroma(4*g + 2, 2))});
        end
    endtask

    task automatic fill(input int mode);
        for (int p = 0; p < 4*N; p++) begin
            case (mode)
                0: begin pr[p] = 0; pg[p] = 0; pb[p] = 0; end
                1: begin pr[p] = 255; pg[p] = 255; pb[p] = 255; end
                2: begin pr[p] = (p % 2 == 0) ? 255 : 0; pg[p] = 0; pb[p] = 0; end
                default: begin
                    pr[p] = int'($urandom_range(0, 255));
                    pg[p] = int'($urandom_range(0, 255));
                    pb[p] = int'($urandom_range(0, 255));
                end
            endcase
        end
        for (int j = 0; j < 2*N; j++) begin
            mem[RGB_BASE + 3*j]     = {8'(pr[2*j]), 8'(pg[2*j])};
            mem[RGB_BASE + 3*j + 1] = {8'(pb[2*j]), 8'(pr[2*j + 1])};
            mem[RGB_BASE + 3*j + 2] = {8'(pg[2*j + 1]), 8'(pb[2*j + 1])};
        end
    endtask

    task automatic start_run(output int ce);
        @(negedge Clock);
        run_id++;
        Enable = 1'b1;
        ce = cyc + 1;
        @(negedge Clock);
        Enable = 1'b0;
    endtask

    task automatic wait_done(input int ce, input string tag, output int dc);
        dc = -1;
        for (int i = 0; i < 24*N + 40; i++) begin
            @(negedge Clock);
            if (Done) begin
                dc = cyc;
                break;
            end
        end
        check({tag, " done cycle"}, dc, ce + 1 + 24*N);
        @(negedge Clock);
        check({tag, " done pulse width"}, {31'd0, Done}, 32'd0);
    endtask

    task automatic run_image(input string tag);
        int ce, dc, base;
        base = wr_count;
        start_run(ce);
        wait_done(ce, tag, dc);
        check({tag, " write count"}, wr_count - base, 4*N);
        check_image(tag);
    endtask

    initial begin
        int ce, dc, base;
        for (int i = 0; i < 262144; i++) mem[i] = '0;
        repeat (3) @(negedge Clock);
        check("reset addr", {14'd0, SRAM_address}, 32'd0);
        check("reset wdata", {16'd0, SRAM_write_data}, 32'd0);
        check("reset we_n", {31'd0, SRAM_we_n}, 32'd1);
        check("reset done", {31'd0, Done}, 32'd0);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        fill(0);
        run_image("black");
        check_word("black Y0 const", Y_BASE, 16'h1010);
        check_word("black Y1 const", Y_BASE + 1, 16'h1010);
        check_word("black U const", U_BASE, 16'h8080);
        check_word("black V const", V_BASE, 16'h8080);

        fill(1);
        run_image("white");
        check_word("white Y const", Y_BASE, 16'hEBEB);
        check_word("white U const", U_BASE, 16'h8080);
        check_word("white V const", V_BASE, 16'h8080);

        fill(2);
        run_image("redblack");
        check_word("redblack Y const", Y_BASE + 3, 16'h5210);
`ifdef YUV_ENC_CHROMA_AVG_EN
        check_word("redblack U const", U_BASE + 1, 16'h6D6D);
        check_word("redblack V const", V_BASE + 1, 16'hB8B8);
`else
        check_word("redblack U const", U_BASE + 1, 16'h5A5A);
        check_word("redblack V const", V_BASE + 1, 16'hF0F0);
`endif

        fill(3);
        run_image("random1");
        fill(3);
        run_image("random2");

        // Abort during S_C5 of group 3 (24*3 + 13 edges after Enable was sampled)
        fill(3);
        start_run(ce);
        while (cyc < ce + 85) @(negedge Clock);
        check("pre-reset addr held", {14'd0, SRAM_address}, RGB_BASE + 6*3 + 5);
        Resetn = 1'b0;
        #1;
        check("async reset addr", {14'd0, SRAM_address}, 32'd0);
        check("async reset wdata", {16'd0, SRAM_write_data}, 32'd0);
        check("async reset we_n", {31'd0, SRAM_we_n}, 32'd1);
        check("async reset done", {31'd0, Done}, 32'd0);
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        base = wr_count;
        repeat (40) @(negedge Clock);
        check("no write after reset", wr_count - base, 0);
        check("idle we_n after reset", {31'd0, SRAM_we_n}, 32'd1);
        run_image("rerun");

        // Enable held high, toggled mid-run: the second image starts only from S_IDLE after Done
        fill(3);
        base = wr_count;
        @(negedge Clock);
        run_id++;
        Enable = 1'b1;
        ce = cyc + 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            Enable = (i % 2 == 0);
        end
        Enable = 1'b1;
        wait_done(ce, "hold1", dc);
        check_image("hold1");
        run_id++;
        @(negedge Clock);
        check("hold2 first addr", {14'd0, SRAM_address}, RGB_BASE);
        check("hold2 first we_n", {31'd0, SRAM_we_n}, 32'd1);
        Enable = 1'b0;
        wait_done(dc + 1, "hold2", dc);
        check("hold write count", wr_count - base, 8*N);
        check_image("hold2");
        base = wr_count;
        repeat (40) @(negedge Clock);
        check("no third run", wr_count - base, 0);

        check("writes in range", oor_count, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
